// File: rtl/block_ram_pkg.sv
// -----------------------------------------------------------------------------
// block_ram_pkg
// Shared types and constants for the byte-enable block RAM (block_ram_be) and
// its storage core (bram_core).
//   bram_state_e : clear-engine state (CLEAR while filling, RUN afterwards)
//   rdw_mode_e   : read-during-write behaviour of the storage template
//   BYTE_W       : width of one byte lane
// -----------------------------------------------------------------------------
package block_ram_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } bram_state_e;

   typedef enum logic {
      READ_FIRST  = 1'b0,
      WRITE_FIRST = 1'b1
   } rdw_mode_e;

endpackage

// File: rtl/bram_core.sv
// -----------------------------------------------------------------------------
// bram_core
// Storage array only: single port, per-byte write enable, synchronous read.
// Written behaviourally so synthesis maps it onto block RAM.
// Ports:
//   clk      in   clock
//   i_en     in   port enable (read and/or write this cycle)
//   i_we     in   write enable (lanes further gated by i_be)
//   i_addr   in   word address
//   i_wdata  in   write data
//   i_be     in   byte-lane enables, bit i gates [8i+7:8i]
//   o_rdata  out  registered read data, updated on every enabled cycle
// RDW_MODE selects what o_rdata shows on a write cycle: the old word
// (READ_FIRST) or the word after the byte merge (WRITE_FIRST).
// -----------------------------------------------------------------------------
module bram_core
   import block_ram_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 8,
   parameter int RDW_MODE = 0
) (
   input  logic                       clk,
   input  logic                       i_en,
   input  logic                       i_we,
   input  logic [ADDR_W-1:0]          i_addr,
   input  logic [DATA_W-1:0]          i_wdata,
   input  logic [DATA_W/BYTE_W-1:0]   i_be,
   output logic [DATA_W-1:0]          o_rdata
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int BE_W  = DATA_W / BYTE_W;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] w_merged;

   // Word as it will look after this cycle's byte-enable write.
   always_comb begin
      w_merged = r_mem[i_addr];
      for (int i = 0; i < BE_W; i++) begin
         if (i_be[i]) begin
            w_merged[i*BYTE_W +: BYTE_W] = i_wdata[i*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (i_en) begin
         if (i_we) begin
            for (int i = 0; i < BE_W; i++) begin
               if (i_be[i]) begin
                  r_mem[i_addr][i*BYTE_W +: BYTE_W] <= i_wdata[i*BYTE_W +: BYTE_W];
               end
            end
         end
         if (i_we && (RDW_MODE == int'(WRITE_FIRST))) begin
            r_rdata <= w_merged;
         end else begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/block_ram_be.sv
// -----------------------------------------------------------------------------
// block_ram_be
// Single-port block RAM with per-byte write enables and a valid/ready request
// port, used as the cache data/tag store. After reset a clear engine writes
// INIT_VAL to every word, one per cycle, before requests are accepted.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle when req_valid is also high
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   req_be     in   byte-lane enables for writes
//   rsp_valid  out  one-cycle pulse, rsp_rdata holds a read result
//   rsp_rdata  out  read data, held between responses
//   init_busy  out  clear engine active
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the requester must hold its request stable until
// then. Responses have no backpressure: a read accepted at edge N shows
// rsp_valid for exactly one cycle after edge N+OUT_REG.
// -----------------------------------------------------------------------------
module block_ram_be
   import block_ram_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 8,
   parameter int                OUT_REG  = 1,
   parameter int                RDW_MODE = 0,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_we,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic [DATA_W-1:0]          req_wdata,
   input  logic [DATA_W/BYTE_W-1:0]   req_be,
   output logic                       rsp_valid,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       init_busy
);

   localparam int BE_W = DATA_W / BYTE_W;

   bram_state_e       r_state;
   bram_state_e       w_next_state;
   logic [ADDR_W-1:0] r_clr_addr;

   logic              w_clearing;
   logic              w_acc;
   logic              w_rd_acc;
   logic              r_v1;

   logic              w_mem_en;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic [BE_W-1:0]   w_mem_be;
   logic [DATA_W-1:0] w_mem_rdata;

   // ---------------- clear FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= CLEAR;
         r_clr_addr <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == CLEAR) begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         CLEAR:   if (r_clr_addr == {ADDR_W{1'b1}}) w_next_state = RUN;
         RUN:     w_next_state = RUN;
         default: w_next_state = CLEAR;
      endcase
   end

   assign w_clearing = (r_state == CLEAR);
   assign req_ready  = (r_state == RUN);
   assign init_busy  = w_clearing;

   // The rst term keeps the array untouched while reset is held, even in the
   // cycle before the state register has returned to CLEAR.
   assign w_acc    = req_valid & req_ready & ~rst;
   assign w_rd_acc = w_acc & ~req_we;

   // ---------------- port mux: clear engine owns the port during CLEAR ----------------
   assign w_mem_en    = ~rst & (w_clearing | w_acc);
   assign w_mem_we    = w_clearing ? 1'b1       : req_we;
   assign w_mem_addr  = w_clearing ? r_clr_addr : req_addr;
   assign w_mem_wdata = w_clearing ? INIT_VAL   : req_wdata;
   assign w_mem_be    = w_clearing ? '1         : req_be;

   bram_core #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .RDW_MODE (RDW_MODE)
   ) u_core (
      .clk     (clk),
      .i_en    (w_mem_en),
      .i_we    (w_mem_we),
      .i_addr  (w_mem_addr),
      .i_wdata (w_mem_wdata),
      .i_be    (w_mem_be),
      .o_rdata (w_mem_rdata)
   );

   // ---------------- response pipeline ----------------
   // Writes also drive the core's read register, so only read accepts are
   // tracked here; that register is never shown on rsp_rdata otherwise.
   always_ff @(posedge clk) begin
      if (rst) r_v1 <= 1'b0;
      else     r_v1 <= w_rd_acc;
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic              r_v2;
         logic [DATA_W-1:0] r_out;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_v2  <= 1'b0;
               r_out <= '0;
            end else begin
               r_v2 <= r_v1;
               if (r_v1) r_out <= w_mem_rdata;
            end
         end

         assign rsp_valid = r_v2;
         assign rsp_rdata = r_out;
      end else begin : g_no_out_reg
         logic [DATA_W-1:0] r_hold;

         // Core output is passed through during the pulse and captured so
         // the last result stays visible afterwards.
         always_ff @(posedge clk) begin
            if (rst)       r_hold <= '0;
            else if (r_v1) r_hold <= w_mem_rdata;
         end

         assign rsp_valid = r_v1;
         assign rsp_rdata = r_v1 ? w_mem_rdata : r_hold;
      end
   endgenerate

endmodule

// File: tb/tb_block_ram_be.sv
// -----------------------------------------------------------------------------
// tb_block_ram_be
// Two instances share one request stream: dut0 (OUT_REG=0, WRITE_FIRST) and
// dut1 (OUT_REG=1, READ_FIRST). The driver updates a word-array model and
// queues each expected read result with the cycle it must appear in; a
// monitor on the falling edge pops and compares against both instances.
// -----------------------------------------------------------------------------
module tb_block_ram_be;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int BEW   = DW / 8;
   localparam logic [DW-1:0] INIT = 32'hA5A5A5A5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic            req_valid = 1'b0;
   logic            req_we    = 1'b0;
   logic [AW-1:0]   req_addr  = '0;
   logic [DW-1:0]   req_wdata = '0;
   logic [BEW-1:0]  req_be    = '0;

   logic            ready0, ready1, rv0, rv1, busy0, busy1;
   logic [DW-1:0]   rd0, rd1;

   block_ram_be #(
      .DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .RDW_MODE(1), .INIT_VAL(INIT)
   ) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready0),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rv0), .rsp_rdata(rd0), .init_busy(busy0)
   );

   block_ram_be #(
      .DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .RDW_MODE(0), .INIT_VAL(INIT)
   ) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rv1), .rsp_rdata(rd1), .init_busy(busy1)
   );

   // ---------------- reference model state ----------------
   int          cyc      = 0;      // rising edges seen
   int          clr_left = DEPTH;  // words still to clear; ready when 0
   logic        rst_q    = 1'b0;   // reset was sampled at the latest edge
   logic [DW-1:0] ref_mem [DEPTH];

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
      if (rst)                clr_left <= DEPTH;
      else if (clr_left != 0) clr_left <= clr_left - 1;
   end

   // ---------------- scoreboard ----------------
   logic [DW-1:0] exp_q0[$];
   logic [DW-1:0] exp_q1[$];
   int            exp_c0[$];
   int            exp_c1[$];
   logic [DW-1:0] last0 = '0;
   logic [DW-1:0] last1 = '0;
   logic [DW-1:0] ed;
   logic          ev0, ev1;
   bit            mon_en = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_q) begin
            // reset edge: reads still in flight are dropped
            exp_q0.delete(); exp_c0.delete();
            exp_q1.delete(); exp_c1.delete();
            last0 = '0;
            last1 = '0;
         end
         chk("ready0", DW'(ready0), DW'(clr_left == 0));
         chk("ready1", DW'(ready1), DW'(clr_left == 0));
         chk("busy0",  DW'(busy0),  DW'(clr_left != 0));
         chk("busy1",  DW'(busy1),  DW'(clr_left != 0));

         while (exp_c0.size() > 0 && exp_c0[0] < cyc) begin
            chk("lost_rsp0", DW'(0), DW'(1));
            void'(exp_q0.pop_front()); void'(exp_c0.pop_front());
         end
         while (exp_c1.size() > 0 && exp_c1[0] < cyc) begin
            chk("lost_rsp1", DW'(0), DW'(1));
            void'(exp_q1.pop_front()); void'(exp_c1.pop_front());
         end

         ev0 = (exp_c0.size() > 0) && (exp_c0[0] == cyc);
         chk("rsp_valid0", DW'(rv0), DW'(ev0));
         if (ev0) begin
            ed = exp_q0.pop_front(); void'(exp_c0.pop_front());
            chk("rdata0", rd0, ed);
            last0 = ed;
         end else begin
            chk("hold0", rd0, last0);
         end

         ev1 = (exp_c1.size() > 0) && (exp_c1[0] == cyc);
         chk("rsp_valid1", DW'(rv1), DW'(ev1));
         if (ev1) begin
            ed = exp_q1.pop_front(); void'(exp_c1.pop_front());
            chk("rdata1", rd1, ed);
            last1 = ed;
         end else begin
            chk("hold1", rd1, last1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      rst       = 1'b1;
      req_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT;
   endtask

   // Present one request and hold it until the model says it is accepted.
   task automatic issue(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BEW-1:0] be);
      int guard;
      guard     = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      while (clr_left != 0 && guard < 4 * DEPTH) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (clr_left != 0) begin
         chk("accept_timeout", DW'(0), DW'(1));
      end else if (we) begin
         for (int i = 0; i < BEW; i++)
            if (be[i]) ref_mem[a][i*8 +: 8] = d[i*8 +: 8];
      end else begin
         // accepted at edge cyc+1; visible after edge cyc+1+OUT_REG
         exp_q0.push_back(ref_mem[a]); exp_c0.push_back(cyc + 1);
         exp_q1.push_back(ref_mem[a]); exp_c1.push_back(cyc + 2);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      do_reset(1);
      mon_en = 1'b1;

      // clear fills every word with INIT; ready timing checked per cycle
      idle(DEPTH);
      for (int i = 0; i < DEPTH; i++) issue(1'b0, AW'(i), '0, '0);
      idle(3);

      // byte-enable merge
      issue(1'b1, 4'd3, 32'h11223344, 4'b1111);
      issue(1'b1, 4'd3, 32'hFFFFFFFF, 4'b0101);
      issue(1'b0, 4'd3, '0, '0);
      issue(1'b1, 4'd4, 32'h01020304, 4'b0000);
      issue(1'b0, 4'd4, '0, '0);

      // read directly after write to the same address
      issue(1'b1, 4'd7, 32'hDEADBEEF, 4'b1111);
      issue(1'b0, 4'd7, '0, '0);
      idle(2);

      // write-only traffic never responds
      repeat (20) issue(1'b1, AW'($urandom_range(0, DEPTH - 1)), $urandom, BEW'($urandom));
      idle(3);

      // reset mid-clear restarts from word 0
      issue(1'b1, 4'd9, 32'h12345678, 4'b1111);
      do_reset(1);
      idle(5);
      do_reset(1);
      idle(DEPTH);
      issue(1'b0, 4'd9, '0, '0);

      // reset with a read in flight
      issue(1'b0, 4'd3, '0, '0);
      do_reset(2);

      // request held during clear is taken on the first RUN cycle
      issue(1'b0, 4'd0, '0, '0);
      issue(1'b0, 4'd9, '0, '0);

      // random mix
      repeat (300) begin
         issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
               $urandom, BEW'($urandom));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
